kiwi_heap_field_store: RTL and testbench
========================================

// Module: kiwi_heap_field_store
// PURPOSE
//  Responder for the object-field accesses that KiwiC-generated initiators issue. It holds N_OBJ heap
//  objects of N_FIELD DW-bit fields. Initiators present handle+field (like ha.left, hb.RPB0) instead of
//  muxing per-object registers. Supports read, write, newobj (allocate and zero) and heap-clear over
//  a valid/ready request and response pair.
// PARAMETERS
//  N_OBJ    4   number of object slots; handles are 0..N_OBJ-1
//  N_FIELD  4   fields per object
//  DW       32  field width in bits (signed data, stored raw)
//  HW       $clog2(N_OBJ)   handle width (derived, localparam)
//  FW       $clog2(N_FIELD) field-index width (derived, localparam)
// PORTS
//  clk          in   1      sole clock, posedge
//  reset        in   1      asynchronous, active-high
//  req_valid    in   1      request present
//  req_ready    out  1      request accepted when req_valid&&req_ready
//  req_op       in   2      00 READ, 01 WRITE, 10 NEWOBJ, 11 CLEAR
//  req_handle   in   HW     object handle (ignored for NEWOBJ/CLEAR)
//  req_field    in   FW     field index (ignored for NEWOBJ/CLEAR)
//  req_wdata    in   DW     write data (WRITE only)
//  rsp_valid    out  1      response present; held until rsp_ready
//  rsp_ready    in   1      response consumed when rsp_valid&&rsp_ready
//  rsp_data     out  DW     read data / echoed wdata / new handle / old count
//  rsp_err      out  1      request rejected, no state change
//  alloc_count  out  HW+1   number of live objects
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, alloc_count=0.
//    Storage array is not reset. Reset mid-ZERO or mid-RESP abandons the operation; no response.
//  - FSM: IDLE -> (accept) EXEC -> RESP; NEWOBJ path is EXEC -> ZERO -> RESP; RESP -> IDLE on rsp_ready.
//    req_ready=1 only in IDLE, so there is one outstanding request.
//  - Latency from accept to rsp_valid: 2 cycles for READ/WRITE/CLEAR/errors, 2+N_FIELD for good NEWOBJ.
//  - Validity: valid when handle<alloc_count && field<N_FIELD. An invalid READ/WRITE gives rsp_err=1,
//    rsp_data=0 and no write. This replaces the 1'bx/32'bx fallthrough of the mux style.
//  - READ: synchronous RAM read in EXEC, rsp_data=mem[handle][field].
//  - WRITE: mem written in EXEC, rsp_data=req_wdata (echo).
//  - NEWOBJ: if alloc_count==N_OBJ then rsp_err=1, rsp_data=0. Otherwise the handle is alloc_count.
//    ZERO writes 0 to fields 0..N_FIELD-1, one per cycle, using a FW+1-bit counter.
//    Then alloc_count increments and rsp_data=new handle (zero-extended).
//  - CLEAR: rsp_data=old alloc_count, alloc_count<=0; never errors.
//  - Request fields are latched at accept; inputs may change afterwards.
//  - Arithmetic: counters are unsigned and do not wrap (alloc_count saturates at N_OBJ by the error rule).
//    Data is passed through unmodified.
//  - rsp_data/rsp_err hold stable while rsp_valid=1 && !rsp_ready. They keep their last value in IDLE.
// STRUCTURE
//  - Shared package kiwi_heap_pkg: op codes (OP_READ/OP_WRITE/OP_NEWOBJ/OP_CLEAR) and the FSM state
//    enum (S_IDLE,S_EXEC,S_ZERO,S_RESP). Other KiwiC heap blocks reuse it.
//  - One sub-module kiwi_heap_ram: N_OBJ*N_FIELD x DW, 1 write port and 1 sync read port.
//    Address is {handle,field} when N_FIELD is a power of two, else handle*N_FIELD+field.
// TESTING
//  1. NEWOBJ x2 -> rsp_data 0 then 1, alloc_count 2; READ h1 f2 -> 0 (zeroed).
//  2. WRITE h0 f0=22, h1 f0=32, h1 f1=1003; READ h1 f0 -> 32, h0 f0 -> 22, h1 f1 -> 1003.
//  3. READ h3 with alloc_count=2 -> rsp_err=1, data 0; a following READ h1 f0 still gives 32.
//  4. Four NEWOBJs then a fifth (N_OBJ=4) -> fifth rsp_err=1, alloc_count stays 4.
//  5. rsp_ready low for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0; req_valid ignored.
//  6. Assert reset during ZERO of NEWOBJ -> next cycle rsp_valid=0, alloc_count=0, req_ready=1.
//     CLEAR afterwards returns 0.

Source files
------------

// File: rtl/kiwi_heap_pkg.sv
// Shared definitions for the KiwiC heap responder blocks: request op codes
// and the request-processing FSM state encoding.
package kiwi_heap_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_NEWOBJ = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_ZERO = 2'b10,
        S_RESP = 2'b11
    } state_e;

endpackage

// File: rtl/kiwi_heap_ram.sv
// Field storage: DEPTH x DW array, one write port and one synchronous read
// port. The array itself has no reset; only the read register is cleared so
// the response data path starts from a known value.
module kiwi_heap_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Read register holds its value unless a read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage write, deliberately without reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/kiwi_heap_field_store.sv
// Heap object field store: answers READ / WRITE / NEWOBJ / CLEAR requests
// addressed by object handle and field index.
//
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// a response transfers on a clock edge where rsp_valid && rsp_ready. The
// producer of valid keeps it and its payload steady until the transfer edge.
// req_ready is high only in IDLE, so at most one request is in flight.
module kiwi_heap_field_store
    import kiwi_heap_pkg::*;
#(
    parameter int N_OBJ   = 4,
    parameter int N_FIELD = 4,
    parameter int DW      = 32,
    localparam int HW     = $clog2(N_OBJ),
    localparam int FW     = $clog2(N_FIELD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [HW-1:0] req_handle,
    input  logic [FW-1:0] req_field,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [HW:0]   alloc_count
);

    localparam int AW = $clog2(N_OBJ * N_FIELD);
    localparam logic [HW:0] MAX_OBJ    = (HW + 1)'(N_OBJ);
    localparam logic [FW:0] NFIELD_W   = (FW + 1)'(N_FIELD);
    localparam logic [FW:0] FIELD_LAST = (FW + 1)'(N_FIELD - 1);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [HW-1:0] handle_q, handle_d;
    logic [FW-1:0] field_q, field_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [HW:0]   alloc_count_q, alloc_count_d;
    logic [FW:0]   zc_q, zc_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    // When set, the response data comes straight from the RAM read register.
    logic          from_ram_q, from_ram_d;

    logic          addr_ok;
    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [HW-1:0] handle_sel;
    logic [FW-1:0] field_sel;
    logic [AW-1:0] ram_addr;

    assign addr_ok = ({1'b0, handle_q} < alloc_count_q) && ({1'b0, field_q} < NFIELD_W);

    // Flat RAM address: plain concatenation when fields are a power of two.
    if ((N_FIELD & (N_FIELD - 1)) == 0) begin : g_addr_pow2
        assign ram_addr = {handle_sel, field_sel};
    end else begin : g_addr_mul
        assign ram_addr = AW'(handle_sel * N_FIELD + field_sel);
    end

    // Next-state, datapath and RAM control for the request FSM.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        handle_d      = handle_q;
        field_d       = field_q;
        wdata_d       = wdata_q;
        alloc_count_d = alloc_count_q;
        zc_d          = zc_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        from_ram_d    = from_ram_q;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        ram_wdata     = '0;
        handle_sel    = handle_q;
        field_sel     = field_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = op_e'(req_op);
                    handle_d = req_handle;
                    field_d  = req_field;
                    wdata_d  = req_wdata;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d    = S_RESP;
                from_ram_d = 1'b0;
                rsp_err_d  = 1'b0;
                case (op_q)
                    OP_READ: begin
                        if (addr_ok) begin
                            ram_re     = 1'b1;
                            from_ram_d = 1'b1;
                        end else begin
                            rsp_err_d  = 1'b1;
                            rsp_data_d = '0;
                        end
                    end
                    OP_WRITE: begin
                        if (addr_ok) begin
                            ram_we     = 1'b1;
                            ram_wdata  = wdata_q;
                            rsp_data_d = wdata_q;
                        end else begin
                            rsp_err_d  = 1'b1;
                            rsp_data_d = '0;
                        end
                    end
                    OP_NEWOBJ: begin
                        if (alloc_count_q == MAX_OBJ) begin
                            rsp_err_d  = 1'b1;
                            rsp_data_d = '0;
                        end else begin
                            // Keep the previous response visible until ZERO ends.
                            state_d    = S_ZERO;
                            from_ram_d = from_ram_q;
                            rsp_err_d  = rsp_err_q;
                            zc_d       = '0;
                        end
                    end
                    default: begin
                        rsp_data_d    = DW'(alloc_count_q);
                        alloc_count_d = '0;
                    end
                endcase
            end
            S_ZERO: begin
                // The new object's handle is the current live count.
                handle_sel = alloc_count_q[HW-1:0];
                field_sel  = zc_q[FW-1:0];
                ram_we     = 1'b1;
                ram_wdata  = '0;
                zc_d       = zc_q + (FW + 1)'(1);
                if (zc_q == FIELD_LAST) begin
                    state_d       = S_RESP;
                    alloc_count_d = alloc_count_q + (HW + 1)'(1);
                    rsp_data_d    = DW'(alloc_count_q);
                    rsp_err_d     = 1'b0;
                    from_ram_d    = 1'b0;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; an asserted reset abandons any operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= OP_READ;
            handle_q      <= '0;
            field_q       <= '0;
            wdata_q       <= '0;
            alloc_count_q <= '0;
            zc_q          <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            from_ram_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            handle_q      <= handle_d;
            field_q       <= field_d;
            wdata_q       <= wdata_d;
            alloc_count_q <= alloc_count_d;
            zc_q          <= zc_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            from_ram_q    <= from_ram_d;
        end
    end

    kiwi_heap_ram #(
        .DEPTH(N_OBJ * N_FIELD),
        .AW   (AW),
        .DW   (DW)
    ) u_ram (
        .clk  (clk),
        .rst  (reset),
        .we   (ram_we),
        .waddr(ram_addr),
        .wdata(ram_wdata),
        .re   (ram_re),
        .raddr(ram_addr),
        .rdata(ram_rdata)
    );

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_data    = from_ram_q ? ram_rdata : rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign alloc_count = alloc_count_q;

endmodule

// File: tb/tb_kiwi_heap_field_store.sv
// Directed bench for kiwi_heap_field_store with a response scoreboard.
module tb_kiwi_heap_field_store;
  import kiwi_heap_pkg::*;

  localparam int N_OBJ   = 4;
  localparam int N_FIELD = 4;
  localparam int DW      = 32;
  localparam int LAT     = 2;
  localparam int LAT_NEW = 2 + N_FIELD;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [1:0]    req_handle;
  logic [1:0]    req_field;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [2:0]    alloc_count;

  logic [DW-1:0] exp_q[$];
  logic          err_q[$];
  int            lat_q[$];

  int checks = 0;
  int errors = 0;

  kiwi_heap_field_store #(
    .N_OBJ  (N_OBJ),
    .N_FIELD(N_FIELD),
    .DW     (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_handle (req_handle),
    .req_field  (req_field),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alloc_count(alloc_count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request/response transaction; stall > 0 holds rsp_ready low that many
  // cycles while a competing CLEAR request is presented.
  task automatic do_req(input logic [1:0] op, input logic [1:0] h, input logic [1:0] f,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_data,
                        input logic exp_err, input int exp_lat, input int stall);
    int n;
    logic [DW-1:0] d_exp;
    logic          e_exp;
    int            l_exp;
    exp_q.push_back(exp_data);
    err_q.push_back(exp_err);
    lat_q.push_back(exp_lat);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_handle = h;
    req_field  = f;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_op     = 2'($urandom_range(0, 3));
    req_handle = 2'($urandom_range(0, 3));
    req_field  = 2'($urandom_range(0, 3));
    req_wdata  = $urandom;
    n = 1;
    while (!rsp_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    d_exp = exp_q.pop_front();
    e_exp = err_q.pop_front();
    l_exp = lat_q.pop_front();
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("latency", n, l_exp);
    check("rsp_data", rsp_data, d_exp);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e_exp});
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_op    = OP_CLEAR;
      @(posedge clk); #1;
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data", rsp_data, d_exp);
      check("stall_err", {31'd0, rsp_err}, {31'd0, e_exp});
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_consumed", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int n;
    logic [DW-1:0] rnd;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_handle = '0;
    req_field  = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_alloc", {29'd0, alloc_count}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // allocate two objects, new fields read as zero
    do_req(OP_NEWOBJ, 2'd3, 2'd3, 32'd0, 32'd0, 1'b0, LAT_NEW, 0);
    do_req(OP_NEWOBJ, 2'd0, 2'd0, 32'd0, 32'd1, 1'b0, LAT_NEW, 0);
    check("alloc_2", {29'd0, alloc_count}, 32'd2);
    do_req(OP_READ, 2'd1, 2'd2, 32'd0, 32'd0, 1'b0, LAT, 0);

    // writes echo data, reads return it
    do_req(OP_WRITE, 2'd0, 2'd0, 32'd22, 32'd22, 1'b0, LAT, 0);
    do_req(OP_WRITE, 2'd1, 2'd0, 32'd32, 32'd32, 1'b0, LAT, 0);
    do_req(OP_WRITE, 2'd1, 2'd1, 32'd1003, 32'd1003, 1'b0, LAT, 0);
    do_req(OP_READ, 2'd1, 2'd0, 32'd0, 32'd32, 1'b0, LAT, 0);
    do_req(OP_READ, 2'd0, 2'd0, 32'd0, 32'd22, 1'b0, LAT, 0);
    do_req(OP_READ, 2'd1, 2'd1, 32'd0, 32'd1003, 1'b0, LAT, 0);

    // out-of-range handles are rejected without side effects
    do_req(OP_READ, 2'd3, 2'd0, 32'd0, 32'd0, 1'b1, LAT, 0);
    do_req(OP_WRITE, 2'd2, 2'd0, 32'd77, 32'd0, 1'b1, LAT, 0);
    do_req(OP_READ, 2'd1, 2'd0, 32'd0, 32'd32, 1'b0, LAT, 0);
    check("alloc_still_2", {29'd0, alloc_count}, 32'd2);

    // clear then fill the heap; the fifth allocation fails
    do_req(OP_CLEAR, 2'd1, 2'd1, 32'd0, 32'd2, 1'b0, LAT, 0);
    check("alloc_cleared", {29'd0, alloc_count}, 32'd0);
    for (int i = 0; i < N_OBJ; i++) begin
      do_req(OP_NEWOBJ, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom,
             DW'(i), 1'b0, LAT_NEW, 0);
    end
    check("alloc_full", {29'd0, alloc_count}, 32'd4);
    do_req(OP_NEWOBJ, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, LAT, 0);
    check("alloc_sat", {29'd0, alloc_count}, 32'd4);
    do_req(OP_READ, 2'd1, 2'd0, 32'd0, 32'd0, 1'b0, LAT, 0);
    do_req(OP_READ, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, LAT, 0);

    // back-pressure on the response; a CLEAR presented meanwhile is ignored
    rnd = $urandom;
    do_req(OP_WRITE, 2'd3, 2'd3, rnd, rnd, 1'b0, LAT, 0);
    do_req(OP_READ, 2'd3, 2'd3, 32'd0, rnd, 1'b0, LAT, 5);
    check("alloc_after_stall", {29'd0, alloc_count}, 32'd4);
    do_req(OP_WRITE, 2'd2, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, LAT, 3);

    // reset in the middle of zeroing abandons the allocation
    do_req(OP_CLEAR, 2'd0, 2'd0, 32'd0, 32'd4, 1'b0, LAT, 0);
    do_req(OP_NEWOBJ, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, LAT_NEW, 0);
    check("alloc_one", {29'd0, alloc_count}, 32'd1);
    req_valid = 1'b1;
    req_op    = OP_NEWOBJ;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_alloc", {29'd0, alloc_count}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) n++;
    end
    check("no_orphan_rsp", n, 32'd0);
    do_req(OP_CLEAR, 2'd0, 2'd0, 32'd0, 32'd0, 1'b0, LAT, 0);
    do_req(OP_READ, 2'd0, 2'd0, 32'd0, 32'd0, 1'b1, LAT, 0);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
